approx_mul_err_monitor: RTL
===========================

# approx_mul_err_monitor

Sequential error-metric accumulator that sits directly downstream of the 8x8 approximate multiplier (4x4 LUT sub-products plus LUT adder). It takes each operand pair and the matching approximate 16-bit product, computes the exact product internally, and accumulates error statistics over a run of N_SAMPLES products. The statistics are sum of error distance, signed error sum, maximum error distance and erroneous-result count. Software or a testbench reads them to derive MED, mean bias and error rate.

## Interface
- N_SAMPLES, default 65536: products per run (1..2^CNT_W-1).
- CNT_W, default 32: width of sample and error counters.
- SUM_W, default 40: width of the accumulators.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE.
- clr  in  1  synchronous abort; returns to IDLE and zeroes all statistics; wins over start.
- in_valid  in  1  operand/product triple valid.
- in_ready  out  1  block accepts the triple this cycle.
- in_a  in  8  multiplicand.
- in_b  in  8  multiplier.
- in_prod  in  16  approximate product of in_a and in_b.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; statistics final.
- sum_ed  out  SUM_W  sum of |exact - approx|, unsigned.
- sum_err  out  SUM_W  sum of (approx - exact), two's complement.
- max_ed  out  16  largest error distance in the run.
- err_cnt  out  CNT_W  count of samples where approx ≠ exact.
- smp_cnt  out  CNT_W  samples accepted in the current run.

## Operation
- FSM states and transitions:
  - IDLE: start → RUN.
  - RUN: → DRAIN on the handshake that makes smp_cnt reach N_SAMPLES.
  - DRAIN: → DONE when the pipeline is empty.
  - DONE: start → RUN.
  - Any state: clr → IDLE.
- in_ready = 1 only in RUN; a handshake is in_valid & in_ready.
- start from IDLE/DONE zeroes sum_ed, sum_err, max_ed, err_cnt, smp_cnt in the same edge it enters RUN. start in RUN or DRAIN is ignored.
- Pipeline per accepted sample:
  - S1 registers exact = in_a*in_b (16-bit unsigned) and in_prod.
  - S2 registers d = approx - exact (17-bit signed), ed = |d| (16-bit) and neq = (d ≠ 0).
  - S3 updates the statistics:
    - sum_ed += ed (zero-extended).
    - sum_err += d (sign-extended).
    - max_ed = max(max_ed, ed).
    - err_cnt += neq.
- smp_cnt increments at the handshake edge, not at S3.
- Accumulators wrap modulo 2^SUM_W. The defaults cannot overflow: 65535·65536 < 2^40.
- in_valid low in RUN inserts bubbles. Bubbles carry valid=0 and do not touch the statistics.
- clr flushes the S1/S2 valid bits.

## Timing
- Reset values: state IDLE; in_ready, busy and done are 0; all statistics are 0; pipeline valid bits are 0.
- Latency: a sample handshaken at edge t appears in sum_ed/sum_err/max_ed/err_cnt after edge t+2, visible in cycle t+3 onward.
- DRAIN lasts exactly 2 cycles after the final handshake. done rises in the cycle after the last S3 update and holds until start or clr.
- in_ready drops in the cycle after the final handshake; no (N_SAMPLES+1)th sample is ever accepted.
- rst_n assertion mid-run aborts immediately and asynchronously, with all outputs at reset values. There is no partial resumption.
- start and clr in the same cycle: clr wins.

## Structure
- Shared package approx_mul_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - the operand width (8) and product width (16) constants;
  - the default N_SAMPLES.
- One sub-module, approx_err_stage: the S1/S2 exact-product and error-distance pipeline with valid propagation.
- The FSM and S3 accumulators live in the top.

## Test plan
- Exact stream: N_SAMPLES=16, in_prod = a*b for all samples → sum_ed=0, sum_err=0, max_ed=0, err_cnt=0, smp_cnt=16, done=1.
- Worst underestimate: single run N_SAMPLES=1, a=255, b=255, prod=0 → sum_ed=65025, sum_err=−65025, max_ed=65025, err_cnt=1.
- Mixed sign: N_SAMPLES=2, samples (a=15,b=15,prod=230) and (a=15,b=15,prod=220) → sum_ed=10, sum_err=0, max_ed=5, err_cnt=2.
- Bubbles and excess input: in_valid toggling randomly, N_SAMPLES=8, in_valid held high after the 8th sample → exactly 8 handshakes; in_ready=0 from the cycle after the 8th; done 3 cycles after the 8th handshake.
- Exhaustive sweep against the real approximate multiplier: all 65536 operand pairs → statistics match the reference model's MED·65536, bias sum, max and error count.
- Reset and abort:
  - rst_n low at sample 5 of 16 → all outputs 0, IDLE.
  - clr in DRAIN → IDLE, statistics 0, no done pulse.
  - start during RUN → ignored, counts continue.

Source files
------------

// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the approximate multiplier error monitor.
// Operand/product widths, FSM state encoding and default run length.
package approx_mul_pkg;

  localparam int          OP_W          = 8;
  localparam int          PROD_W        = 16;
  localparam int unsigned N_SAMPLES_DEF = 65536;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/approx_err_stage.sv
// Two-stage pipeline: exact product (S1), then signed error,
// error distance and mismatch flag (S2), with valid propagation.
module approx_err_stage
  import approx_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic              s1_valid_o,
  output logic              valid_o,
  output logic [PROD_W:0]   d_o,
  output logic [PROD_W-1:0] ed_o,
  output logic              neq_o
);

  logic              s1_valid_q;
  logic [PROD_W-1:0] exact_q;
  logic [PROD_W-1:0] approx_q;
  logic              s2_valid_q;
  logic [PROD_W:0]   d_q;
  logic [PROD_W-1:0] ed_q;
  logic              neq_q;

  logic [PROD_W:0]   d_d;
  logic [PROD_W:0]   neg_d;
  logic [PROD_W-1:0] ed_d;

  // Signed error and its magnitude from the S1 registers
  always_comb begin
    d_d   = {1'b0, approx_q} - {1'b0, exact_q};
    neg_d = ~d_d + {{PROD_W{1'b0}}, 1'b1};
    ed_d  = d_d[PROD_W] ? neg_d[PROD_W-1:0]
                        : d_d[PROD_W-1:0];
  end

  // S1: capture exact product and the approximate product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      exact_q    <= '0;
      approx_q   <= '0;
    end else begin
      s1_valid_q <= valid_i & ~flush_i;
      if (valid_i) begin
        exact_q  <= PROD_W'(a_i) * PROD_W'(b_i);
        approx_q <= prod_i;
      end
    end
  end

  // S2: register error metrics for the accumulator stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      d_q        <= '0;
      ed_q       <= '0;
      neq_q      <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q & ~flush_i;
      if (s1_valid_q) begin
        d_q   <= d_d;
        ed_q  <= ed_d;
        neq_q <= |d_d;
      end
    end
  end

  assign s1_valid_o = s1_valid_q;
  assign valid_o    = s2_valid_q;
  assign d_o        = d_q;
  assign ed_o       = ed_q;
  assign neq_o      = neq_q;

endmodule

// File: rtl/approx_mul_err_monitor.sv
// Run-based error statistics for the 8x8 approximate multiplier:
// run FSM, sample counter and S3 accumulators.
module approx_mul_err_monitor
  import approx_mul_pkg::*;
#(
  parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
  parameter int          CNT_W     = 32,
  parameter int          SUM_W     = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [PROD_W-1:0] in_prod,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum_ed,
  output logic [SUM_W-1:0]  sum_err,
  output logic [PROD_W-1:0] max_ed,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  smp_cnt
);

  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);

  state_e            state_q, state_d;
  logic [SUM_W-1:0]  sum_ed_q;
  logic [SUM_W-1:0]  sum_err_q;
  logic [PROD_W-1:0] max_ed_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  smp_cnt_q;

  logic              hs;
  logic              last;
  logic              go;
  logic              s1_valid;
  logic              s2_valid;
  logic [PROD_W:0]   s2_d;
  logic [PROD_W-1:0] s2_ed;
  logic              s2_neq;

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN) | (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign hs       = in_valid & in_ready;
  assign last     = hs & ((smp_cnt_q + CNT_W'(1)) == N_LAST);
  assign go       = start & ~clr &
                    ((state_q == IDLE) | (state_q == DONE));

  approx_err_stage u_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (clr),
    .valid_i    (hs),
    .a_i        (in_a),
    .b_i        (in_b),
    .prod_i     (in_prod),
    .s1_valid_o (s1_valid),
    .valid_o    (s2_valid),
    .d_o        (s2_d),
    .ed_o       (s2_ed),
    .neq_o      (s2_neq)
  );

  // Run FSM next-state; clr overrides everything
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start)     state_d = RUN;
        RUN:     if (last)      state_d = DRAIN;
        DRAIN:   if (!s1_valid) state_d = DONE;
        DONE:    if (start)     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Sample counter and S3 statistics accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed_q  <= '0;
      sum_err_q <= '0;
      max_ed_q  <= '0;
      err_cnt_q <= '0;
      smp_cnt_q <= '0;
    end else if (clr | go) begin
      sum_ed_q  <= '0;
      sum_err_q <= '0;
      max_ed_q  <= '0;
      err_cnt_q <= '0;
      smp_cnt_q <= '0;
    end else begin
      if (hs) smp_cnt_q <= smp_cnt_q + CNT_W'(1);
      if (s2_valid) begin
        sum_ed_q  <= sum_ed_q + SUM_W'(s2_ed);
        sum_err_q <= sum_err_q + SUM_W'($signed(s2_d));
        if (s2_ed > max_ed_q) max_ed_q <= s2_ed;
        err_cnt_q <= err_cnt_q + CNT_W'(s2_neq);
      end
    end
  end

  assign sum_ed  = sum_ed_q;
  assign sum_err = sum_err_q;
  assign max_ed  = max_ed_q;
  assign err_cnt = err_cnt_q;
  assign smp_cnt = smp_cnt_q;

endmodule
